cpu_control_unit: RTL and testbench

- Fetch/execute sequencer for the 4-bit CPU.
- Fetches 8-bit instructions from program ROM and drives the 4-bit adder ALU operands.
- Writes the ALU sum back to registers A, B or the output port.
- Keeps the zero flag and resolves jumps from it; it is the consumer side of the ALU's sum/zero-flag interface.
- Two-state FSM, two clocks per instruction.

---
 rtl/cpu_control_unit.sv | 120 ++++++++++++
 tb/tb_cpu_control_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
// Fetch/execute sequencer for the 4-bit CPU: two clocks per instruction,
// routes all data writes through the external adder and tracks the zero flag.
module cpu_control_unit #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [3:0] alu_s,
  output logic [3:0] out_port,
  output logic       zf,
  output logic       fetch
);

  typedef enum logic {S_FETCH, S_EXEC} state_t;
  typedef enum logic [1:0] {D_NONE, D_A, D_B, D_OUT} dst_t;

  typedef struct packed {
    logic [3:0] opa;
    logic [3:0] opb;
    dst_t       dst;
    logic       jump;
  } dec_t;

  state_t     state, state_n;
  logic [3:0] pc, pc_n;
  logic [3:0] ra, ra_n;
  logic [3:0] rb, rb_n;
  logic [7:0] ir, ir_n;
  logic [3:0] out_n;
  logic       zf_n;
  dec_t       dec;

  logic [3:0] opc, im;
  assign opc = ir[7:4];
  assign im  = ir[3:0];

  // Decode is a pure function of IR and registers; operands are valid in
  // both states but only consumed at the EXEC edge.
  always_comb begin
    dec.opa  = 4'h0;
    dec.opb  = 4'h0;
    dec.dst  = D_NONE;
    dec.jump = 1'b0;
    case (opc)
      4'b0000: begin dec.opa = ra;      dec.opb = im;   dec.dst = D_A;   end
      4'b0101: begin dec.opa = rb;      dec.opb = im;   dec.dst = D_B;   end
      4'b0011: begin dec.opa = 4'h0;    dec.opb = im;   dec.dst = D_A;   end
      4'b0111: begin dec.opa = 4'h0;    dec.opb = im;   dec.dst = D_B;   end
      4'b0001: begin dec.opa = rb;      dec.opb = 4'h0; dec.dst = D_A;   end
      4'b0100: begin dec.opa = ra;      dec.opb = 4'h0; dec.dst = D_B;   end
      4'b0010: begin dec.opa = in_port; dec.opb = im;   dec.dst = D_A;   end
      4'b0110: begin dec.opa = in_port; dec.opb = im;   dec.dst = D_B;   end
      4'b1001: begin dec.opa = rb;      dec.opb = im;   dec.dst = D_OUT; end
      4'b1011: begin dec.opa = 4'h0;    dec.opb = im;   dec.dst = D_OUT; end
      4'b1111: dec.jump = 1'b1;
      4'b1110: dec.jump = ~zf;
      4'b1101: dec.jump = zf;
      default: ;
    endcase
  end

  assign alu_a    = dec.opa;
  assign alu_b    = dec.opb;
  assign rom_addr = pc;
  assign fetch    = (state == S_FETCH);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    ra_n    = ra;
    rb_n    = rb;
    ir_n    = ir;
    out_n   = out_port;
    zf_n    = zf;
    case (state)
      S_FETCH: begin
        ir_n    = rom_data;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        case (dec.dst)
          D_A:     ra_n  = alu_s;
          D_B:     rb_n  = alu_s;
          D_OUT:   out_n = alu_s;
          default: ;
        endcase
        if (dec.dst != D_NONE) zf_n = (alu_s == 4'h0);
        pc_n    = dec.jump ? im : pc + 4'h1;
        state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ra       <= 4'h0;
      rb       <= 4'h0;
      ir       <= 8'h00;
      out_port <= 4'h0;
      zf       <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ra       <= ra_n;
      rb       <= rb_n;
      ir       <= ir_n;
      out_port <= out_n;
      zf       <= zf_n;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: ROM and adder modelled here, instruction-level
// reference model checked after every EXEC edge.
module tb_cpu_control_unit;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rom_addr, in_port, alu_a, alu_b, alu_s, out_port;
  logic [7:0] rom_data;
  logic       zf, fetch;
  logic [7:0] rom [16];

  int checks = 0;
  int errors = 0;

  // instruction-level architectural model
  int m_pc, m_a, m_b, m_out, m_zf;

  cpu_control_unit #(.RESET_PC(4'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .in_port(in_port), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .out_port(out_port), .zf(zf), .fetch(fetch)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];
  assign alu_s    = alu_a + alu_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_zf = 0;
  endtask

  // Executes one instruction the way the ISA describes it.
  task automatic model_step(input int inp);
    int op, im, r;
    op = rom[m_pc] >> 4;
    im = rom[m_pc] & 15;
    r  = -1;
    case (op)
      0:  begin r = (m_a + im) % 16; m_a = r; end
      5:  begin r = (m_b + im) % 16; m_b = r; end
      3:  begin r = im;              m_a = r; end
      7:  begin r = im;              m_b = r; end
      1:  begin r = m_b;             m_a = r; end
      4:  begin r = m_a;             m_b = r; end
      2:  begin r = (inp + im) % 16; m_a = r; end
      6:  begin r = (inp + im) % 16; m_b = r; end
      9:  begin r = (m_b + im) % 16; m_out = r; end
      11: begin r = im;              m_out = r; end
      default: ;
    endcase
    if (r >= 0) m_zf = (r == 0);
    if (op == 15 || (op == 14 && m_zf == 0) || (op == 13 && m_zf == 1)) m_pc = im;
    else m_pc = (m_pc + 1) % 16;
  endtask

  task automatic cmp_state(input string tag);
    chk({tag, ".pc"},  {4'h0, rom_addr},  8'(m_pc));
    chk({tag, ".a"},   {4'h0, dut.ra},    8'(m_a));
    chk({tag, ".b"},   {4'h0, dut.rb},    8'(m_b));
    chk({tag, ".out"}, {4'h0, out_port},  8'(m_out));
    chk({tag, ".zf"},  {7'h0, zf},        8'(m_zf));
    chk({tag, ".fetch"}, {7'h0, fetch},   8'h01);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    model_reset();
    cmp_state(tag);
  endtask

  // One full instruction; when toggle is set in_port carries junk in FETCH.
  task automatic run_instr(input string tag, input logic [3:0] inp, input bit toggle);
    in_port = toggle ? ~inp : inp;
    tick();
    chk({tag, ".exec"}, {7'h0, fetch}, 8'h00);
    in_port = inp;
    model_step(int'(inp));
    tick();
    cmp_state(tag);
  endtask

  task automatic load(input logic [7:0] p [16]);
    for (int i = 0; i < 16; i++) rom[i] = p[i];
  endtask

  initial begin
    logic [7:0] p [16];
    in_port = 4'h0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;

    // reset mid-program
    tick(); rst_n = 1'b1;
    repeat (5) tick();
    do_reset("reset");
    chk("reset.addr0", {4'h0, rom_addr}, 8'h00);

    // arithmetic and wrap
    for (int i = 0; i < 16; i++) p[i] = 8'h80;
    p[0] = 8'h3E; p[1] = 8'h01; p[2] = 8'h01; p[3] = 8'hB5;
    load(p); do_reset("arith.rst");
    run_instr("arith.mov", 4'h0, 0);
    run_instr("arith.add1", 4'h0, 0);
    chk("arith.AisF", {4'h0, dut.ra}, 8'h0F);
    run_instr("arith.wrap", 4'h0, 0);
    chk("arith.A0", {4'h0, dut.ra}, 8'h00);
    chk("arith.zf1", {7'h0, zf}, 8'h01);
    run_instr("arith.out", 4'h0, 0);
    chk("arith.out5", {4'h0, out_port}, 8'h05);
    chk("arith.zf0", {7'h0, zf}, 8'h00);

    // conditional loop then self-loop
    for (int i = 0; i < 16; i++) p[i] = 8'h80;
    p[0] = 8'h3D; p[1] = 8'h01; p[2] = 8'hE1; p[3] = 8'hB9; p[4] = 8'hF4;
    load(p); do_reset("loop.rst");
    for (int i = 0; i < 8; i++) run_instr("loop", 4'h0, 0);
    chk("loop.out9", {4'h0, out_port}, 8'h09);
    for (int i = 0; i < 3; i++) run_instr("loop.self", 4'h0, 0);
    chk("loop.pc4", {4'h0, rom_addr}, 8'h04);

    // moves and I/O with junk on in_port during FETCH
    for (int i = 0; i < 16; i++) p[i] = 8'h80;
    p[0] = 8'h21; p[1] = 8'h40; p[2] = 8'h52; p[3] = 8'h90;
    load(p); do_reset("io.rst");
    for (int i = 0; i < 4; i++) run_instr("io", 4'h6, 1);
    chk("io.A7", {4'h0, dut.ra}, 8'h07);
    chk("io.B9", {4'h0, dut.rb}, 8'h09);
    chk("io.out9", {4'h0, out_port}, 8'h09);

    // PC wrap over NOPs
    for (int i = 0; i < 16; i++) p[i] = 8'h80;
    load(p); do_reset("nop.rst");
    for (int i = 0; i < 17; i++) run_instr("nop", 4'h0, 0);
    chk("nop.pc1", {4'h0, rom_addr}, 8'h01);

    // JZ fall-through and taken
    p[0] = 8'h31; p[1] = 8'hD5; p[2] = 8'h30; p[3] = 8'hD7;
    load(p); do_reset("jz.rst");
    run_instr("jz", 4'h0, 0); run_instr("jz.nt", 4'h0, 0);
    chk("jz.fall", {4'h0, rom_addr}, 8'h02);
    run_instr("jz", 4'h0, 0); run_instr("jz.t", 4'h0, 0);
    chk("jz.taken", {4'h0, rom_addr}, 8'h07);

    // reset lands on EXEC of ADD A,3 with A=2
    for (int i = 0; i < 16; i++) p[i] = 8'h80;
    p[0] = 8'h32; p[1] = 8'h03;
    load(p); do_reset("rx.rst");
    run_instr("rx.mov", 4'h0, 0);
    tick();
    chk("rx.inexec", {7'h0, fetch}, 8'h00);
    rst_n = 1'b0;
    tick();
    chk("rx.A0", {4'h0, dut.ra}, 8'h00);
    chk("rx.pc0", {4'h0, rom_addr}, 8'h00);
    chk("rx.fetch", {7'h0, fetch}, 8'h01);
    do_reset("rx.rel");

    // random programs
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 16; i++) p[i] = 8'($urandom);
      load(p); do_reset("rnd.rst");
      for (int k = 0; k < 40; k++)
        run_instr("rnd", 4'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end
endmodule
